if_id_pipe_reg: RTL and testbench

- Parametrised fetch/decode pipeline register. It is the next generation of the plain IF/ID latch.
- Adds a per-stage valid bit, bubble insertion on flush, and debug single-step with one-shot edge detection.
- Adds a HALT-capture state that freezes the stage until resumed.
- Sits between the fetch stage (PC+4, instruction memory) and the decode stage. It is also driven by the hazard unit and the debug unit.

---
 rtl/if_id_pipe_reg_pkg.sv | 16 +
 rtl/if_id_pipe_reg_if.sv | 52 +++++
 rtl/step_oneshot.sv | 22 ++
 rtl/if_id_pipe_reg.sv | 115 +++++++++++
 tb/tb_if_id_pipe_reg.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/if_id_pipe_reg_pkg.sv
// Shared definitions for the IF/ID pipeline register family: default widths,
// bubble/halt encodings and the stage state type.
package if_id_pipe_reg_pkg;

  localparam int NB_INSTR_DEF = 32;
  localparam int NB_PC_DEF    = 32;

  localparam logic [31:0] NOP_INSTR_DEF  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Fetch/hazard/debug-facing bundle of the IF/ID register.
// The counter outputs exist only when IF_ID_PERF_CNT_EN is defined.
interface if_id_pipe_reg_if
  import if_id_pipe_reg_pkg::*;
#(
  parameter int NB_INSTR = NB_INSTR_DEF,
  parameter int NB_PC    = NB_PC_DEF
`ifdef IF_ID_PERF_CNT_EN
  ,
  parameter int NB_CNT   = 16
`endif
);

  logic                i_valid;
  logic [NB_PC-1:0]    i_pc4;
  logic [NB_INSTR-1:0] i_instruction;
  logic                i_flush;
  logic                i_stall;
  logic                i_debug_mode;
  logic                i_step;
  logic                i_resume;

  logic                o_valid;
  logic [NB_PC-1:0]    o_pc4;
  logic [NB_INSTR-1:0] o_instruction;
  logic                o_halted;
  logic                o_advance;
`ifdef IF_ID_PERF_CNT_EN
  logic [NB_CNT-1:0]   o_stall_cnt;
  logic [NB_CNT-1:0]   o_flush_cnt;
`endif

  // Upstream side: fetch, hazard and debug units drive the requests.
  modport master (
    output i_valid, i_pc4, i_instruction, i_flush, i_stall,
           i_debug_mode, i_step, i_resume,
    input  o_valid, o_pc4, o_instruction, o_halted, o_advance
`ifdef IF_ID_PERF_CNT_EN
    , input o_stall_cnt, o_flush_cnt
`endif
  );

  modport slave (
    input  i_valid, i_pc4, i_instruction, i_flush, i_stall,
           i_debug_mode, i_step, i_resume,
    output o_valid, o_pc4, o_instruction, o_halted, o_advance
`ifdef IF_ID_PERF_CNT_EN
    , output o_stall_cnt, o_flush_cnt
`endif
  );

endinterface

// File: rtl/step_oneshot.sv
// Falling-edge one-shot for a level debug step request; a held request
// produces a single pulse and re-arms after one low edge.
module step_oneshot (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_step,
  output logic o_pulse
);

  logic step_armed_reg;

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      step_armed_reg <= 1'b1;
    end else begin
      step_armed_reg <= !i_step;
    end
  end

  assign o_pulse = i_step & step_armed_reg;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid bit, flush bubbles, debug single-step and
// HALT capture. Define IF_ID_PERF_CNT_EN to add saturating stall/flush counters.
module if_id_pipe_reg
  import if_id_pipe_reg_pkg::*;
#(
  parameter int                  NB_INSTR   = NB_INSTR_DEF,
  parameter int                  NB_PC      = NB_PC_DEF,
  parameter logic [NB_INSTR-1:0] NOP_INSTR  = NB_INSTR'(NOP_INSTR_DEF),
  parameter logic [NB_INSTR-1:0] HALT_INSTR = NB_INSTR'(HALT_INSTR_DEF)
`ifdef IF_ID_PERF_CNT_EN
  ,
  parameter int                  NB_CNT     = 16
`endif
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  if_id_pipe_reg_if.slave bus
);

  state_e              state_reg, state_next;
  logic                valid_reg, valid_next;
  logic [NB_PC-1:0]    pc4_reg, pc4_next;
  logic [NB_INSTR-1:0] instr_reg, instr_next;
  logic                advance_reg, advance_next;

  logic step_pulse;
  logic adv_en;

  step_oneshot u_step_oneshot (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_step    (bus.i_step),
    .o_pulse   (step_pulse)
  );

  assign adv_en = !bus.i_debug_mode | step_pulse;

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= ST_RUN;
      valid_reg   <= 1'b0;
      pc4_reg     <= '0;
      instr_reg   <= NOP_INSTR;
      advance_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      valid_reg   <= valid_next;
      pc4_reg     <= pc4_next;
      instr_reg   <= instr_next;
      advance_reg <= advance_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    valid_next   = valid_reg;
    pc4_next     = pc4_reg;
    instr_next   = instr_reg;
    advance_next = 1'b0;
    if (state_reg == ST_RUN) begin
      if (bus.i_flush) begin
        // The PC survives the bubble so halt/debug tools still see where it was.
        valid_next = 1'b0;
        instr_next = NOP_INSTR;
        pc4_next   = bus.i_pc4;
      end else if (bus.i_stall) begin
        state_next = ST_RUN;
      end else if (adv_en) begin
        valid_next   = bus.i_valid;
        pc4_next     = bus.i_pc4;
        instr_next   = bus.i_instruction;
        advance_next = 1'b1;
        if (bus.i_valid && (bus.i_instruction == HALT_INSTR)) begin
          state_next = ST_HALTED;
        end
      end
    end else if (bus.i_resume) begin
      state_next = ST_RUN;
    end
  end

  assign bus.o_valid       = valid_reg;
  assign bus.o_pc4         = pc4_reg;
  assign bus.o_instruction = instr_reg;
  assign bus.o_halted      = (state_reg == ST_HALTED);
  assign bus.o_advance     = advance_reg;

`ifdef IF_ID_PERF_CNT_EN
  logic [NB_CNT-1:0] stall_cnt_reg;
  logic [NB_CNT-1:0] flush_cnt_reg;
  logic              stall_hit;
  logic              flush_hit;

  assign flush_hit = (state_reg == ST_RUN) && bus.i_flush;
  assign stall_hit = (state_reg == ST_RUN) && !bus.i_flush && bus.i_stall;

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_hit && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + NB_CNT'(1);
      end
      if (flush_hit && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + NB_CNT'(1);
      end
    end
  end

  assign bus.o_stall_cnt = stall_cnt_reg;
  assign bus.o_flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Table-driven bench for if_id_pipe_reg: each vector is one falling edge, with
// expected outputs queued on drive and compared after the edge.
module tb_if_id_pipe_reg;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        flush;
    logic        stall;
    logic        dbg;
    logic        step;
    logic        resume;
    logic        e_valid;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    logic        e_halted;
    logic        e_adv;
  } vec_t;

  logic clk = 1'b1;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  if_id_pipe_reg_if #(.NB_INSTR(32), .NB_PC(32)) bus ();

  if_id_pipe_reg dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
  endtask

  function automatic vec_t mk(input string nm, input logic v, input logic [31:0] pc,
                              input logic [31:0] ins, input logic fl, input logic st,
                              input logic dbg, input logic stp, input logic res,
                              input logic ev, input logic [31:0] epc, input logic [31:0] eins,
                              input logic eh, input logic ea);
    vec_t r;
    r.name = nm; r.valid = v; r.pc4 = pc; r.instr = ins; r.flush = fl; r.stall = st;
    r.dbg = dbg; r.step = stp; r.resume = res; r.e_valid = ev; r.e_pc4 = epc;
    r.e_instr = eins; r.e_halted = eh; r.e_adv = ea;
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    vec_t e;
    bus.i_valid = v.valid; bus.i_pc4 = v.pc4; bus.i_instruction = v.instr;
    bus.i_flush = v.flush; bus.i_stall = v.stall; bus.i_debug_mode = v.dbg;
    bus.i_step = v.step; bus.i_resume = v.resume;
    exp_q.push_back(v);
    @(negedge clk);
    #1;
    e = exp_q.pop_front();
    $display("%-14s valid=%b pc4=%h instr=%h halted=%b adv=%b", e.name,
             bus.o_valid, bus.o_pc4, bus.o_instruction, bus.o_halted, bus.o_advance);
    chk({e.name, ".valid"},  32'(bus.o_valid),     32'(e.e_valid));
    chk({e.name, ".pc4"},    bus.o_pc4,            e.e_pc4);
    chk({e.name, ".instr"},  bus.o_instruction,    e.e_instr);
    chk({e.name, ".halted"}, 32'(bus.o_halted),    32'(e.e_halted));
    chk({e.name, ".adv"},    32'(bus.o_advance),   32'(e.e_adv));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".valid"},  32'(bus.o_valid),   32'd0);
    chk({nm, ".pc4"},    bus.o_pc4,          32'd0);
    chk({nm, ".instr"},  bus.o_instruction,  32'h0000_0000);
    chk({nm, ".halted"}, 32'(bus.o_halted),  32'd0);
    chk({nm, ".adv"},    32'(bus.o_advance), 32'd0);
  endtask

  initial begin
    bus.i_valid = 0; bus.i_pc4 = 0; bus.i_instruction = 0; bus.i_flush = 0;
    bus.i_stall = 0; bus.i_debug_mode = 0; bus.i_step = 0; bus.i_resume = 0;

    //            name            v  pc4    instr         fl st db sp rs   ev epc    einstr        eh ea
    vecs.push_back(mk("load",      1, 32'h04, 32'h2002_0005, 0, 0, 0, 0, 0,  1, 32'h04, 32'h2002_0005, 0, 1));
    vecs.push_back(mk("stall1",    1, 32'h08, 32'h1111_0008, 0, 1, 0, 0, 0,  1, 32'h04, 32'h2002_0005, 0, 0));
    vecs.push_back(mk("stall2",    1, 32'h0C, 32'h1111_000C, 0, 1, 0, 0, 0,  1, 32'h04, 32'h2002_0005, 0, 0));
    vecs.push_back(mk("stall3",    1, 32'h10, 32'h1111_0010, 0, 1, 0, 0, 0,  1, 32'h04, 32'h2002_0005, 0, 0));
    vecs.push_back(mk("flush_stl", 1, 32'h20, 32'h1111_0020, 1, 1, 0, 0, 0,  0, 32'h20, 32'h0000_0000, 0, 0));
    vecs.push_back(mk("step_a",    1, 32'h24, 32'hA000_0024, 0, 0, 1, 1, 0,  1, 32'h24, 32'hA000_0024, 0, 1));
    vecs.push_back(mk("step_b",    1, 32'h28, 32'hA000_0028, 0, 0, 1, 1, 0,  1, 32'h24, 32'hA000_0024, 0, 0));
    vecs.push_back(mk("step_c",    1, 32'h2C, 32'hA000_002C, 0, 0, 1, 1, 0,  1, 32'h24, 32'hA000_0024, 0, 0));
    vecs.push_back(mk("step_d",    1, 32'h30, 32'hA000_0030, 0, 0, 1, 1, 0,  1, 32'h24, 32'hA000_0024, 0, 0));
    vecs.push_back(mk("step_e",    1, 32'h34, 32'hA000_0034, 0, 0, 1, 1, 0,  1, 32'h24, 32'hA000_0024, 0, 0));
    vecs.push_back(mk("step_rel",  1, 32'h38, 32'hA000_0038, 0, 0, 1, 0, 0,  1, 32'h24, 32'hA000_0024, 0, 0));
    vecs.push_back(mk("step_2nd",  1, 32'h3C, 32'hA000_003C, 0, 0, 1, 1, 0,  1, 32'h3C, 32'hA000_003C, 0, 1));
    vecs.push_back(mk("halt_load", 1, 32'h40, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,  1, 32'h40, 32'hFFFF_FFFF, 1, 1));
    vecs.push_back(mk("hlt_flush", 1, 32'h44, 32'h0000_0044, 1, 0, 0, 0, 0,  1, 32'h40, 32'hFFFF_FFFF, 1, 0));
    vecs.push_back(mk("hlt_step",  1, 32'h48, 32'h0000_0048, 0, 0, 1, 1, 0,  1, 32'h40, 32'hFFFF_FFFF, 1, 0));
    vecs.push_back(mk("hlt_stall", 1, 32'h4C, 32'h0000_004C, 0, 1, 0, 0, 0,  1, 32'h40, 32'hFFFF_FFFF, 1, 0));
    vecs.push_back(mk("hlt_data",  1, 32'h50, 32'h1234_5678, 0, 0, 0, 0, 0,  1, 32'h40, 32'hFFFF_FFFF, 1, 0));
    vecs.push_back(mk("resume",    1, 32'h54, 32'h0000_0054, 0, 0, 0, 0, 1,  1, 32'h40, 32'hFFFF_FFFF, 0, 0));
    vecs.push_back(mk("post_res",  1, 32'h58, 32'h0000_0058, 0, 0, 0, 0, 0,  1, 32'h58, 32'h0000_0058, 0, 1));
    vecs.push_back(mk("halt_inv",  0, 32'h5C, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,  0, 32'h5C, 32'hFFFF_FFFF, 0, 1));
    vecs.push_back(mk("step_nodb", 1, 32'h60, 32'h0000_0060, 0, 0, 0, 1, 0,  1, 32'h60, 32'h0000_0060, 0, 1));
    vecs.push_back(mk("step_held", 1, 32'h64, 32'h0000_0064, 0, 0, 1, 1, 0,  1, 32'h60, 32'h0000_0060, 0, 0));
    vecs.push_back(mk("rearm",     1, 32'h68, 32'h0000_0068, 0, 0, 1, 0, 0,  1, 32'h60, 32'h0000_0060, 0, 0));
    vecs.push_back(mk("step_stl",  1, 32'h6C, 32'h0000_006C, 0, 1, 1, 1, 0,  1, 32'h60, 32'h0000_0060, 0, 0));
    vecs.push_back(mk("step_lost", 1, 32'h70, 32'h0000_0070, 0, 0, 1, 1, 0,  1, 32'h60, 32'h0000_0060, 0, 0));
    vecs.push_back(mk("run_again", 1, 32'h74, 32'h0000_0074, 0, 0, 0, 0, 0,  1, 32'h74, 32'h0000_0074, 0, 1));
    vecs.push_back(mk("halt_2",    1, 32'h78, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,  1, 32'h78, 32'hFFFF_FFFF, 1, 1));

    #2;
    chk_reset("reset");
`ifdef IF_ID_PERF_CNT_EN
    chk("reset.stall_cnt", 32'(bus.o_stall_cnt), 32'd0);
    chk("reset.flush_cnt", 32'(bus.o_flush_cnt), 32'd0);
`endif
    #6 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
`ifdef IF_ID_PERF_CNT_EN
      if (vecs[i].name == "stall3") chk("stall_cnt3", 32'(bus.o_stall_cnt), 32'd3);
`endif
    end

`ifdef IF_ID_PERF_CNT_EN
    // RUN stalls: stall1..3 and step_stl; the halted-state stall/flush are ignored.
    chk("stall_cnt", 32'(bus.o_stall_cnt), 32'd4);
    chk("flush_cnt", 32'(bus.o_flush_cnt), 32'd1);
`endif

    // Asynchronous reset while halted, mid-cycle with no clock edge pending.
    #3 rst_n = 1'b0;
    #1;
    $display("async_reset    valid=%b pc4=%h instr=%h halted=%b adv=%b",
             bus.o_valid, bus.o_pc4, bus.o_instruction, bus.o_halted, bus.o_advance);
    chk_reset("async_rst");
`ifdef IF_ID_PERF_CNT_EN
    chk("async_rst.stall_cnt", 32'(bus.o_stall_cnt), 32'd0);
    chk("async_rst.flush_cnt", 32'(bus.o_flush_cnt), 32'd0);
`endif
    #2 rst_n = 1'b1;
    run_vec(mk("after_rst", 1, 32'h80, 32'h0000_0080, 0, 0, 0, 0, 0, 1, 32'h80, 32'h0000_0080, 0, 1));
    // Step one-shot must be re-armed by reset.
    run_vec(mk("rst_step",  1, 32'h84, 32'h0000_0084, 0, 0, 1, 1, 0, 1, 32'h84, 32'h0000_0084, 0, 1));

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
